matrix_scan_driver: RTL and testbench
=====================================

MATRIX_SCAN_DRIVER -- requirements
Module: matrix_scan_driver

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- CLK_DIV, 2, clk cycles per ser_clk half-period; legal range 1..255.
- HOLD_CYCLES, 1000, clk cycles a latched row is held before the next row starts; legal range 1..65535.
- ROW_ACTIVE_LOW, 1, invert the row-select field before shifting.
- COL_ACTIVE_LOW, 0, invert the column-data field before shifting.

REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, input, 1, clock.
- reset, input, 1, reset, synchronous, active-high.
- enable, input, 1, start or continue frame scanning.
- mat, input, [7:0][7:0], cell matrix from the automaton core; mat[r][c] = cell at row r, column c.
- ser_data, output, 1, serial data to the external shift-register chain.
- ser_clk, output, 1, shift clock; the chain samples on its rising edge.
- ser_latch, output, 1, storage-register latch pulse, active-high.
- frame_done, output, 1, one-cycle pulse after row 7 completes its hold.
- busy, output, 1, high in every state except IDLE.

Function
REQ-003 The FSM SHALL have exactly five states: IDLE, LOAD, SHIFT, LATCH, HOLD.
REQ-004 IDLE with enable=1 SHALL go to LOAD on the next cycle; IDLE with enable=0 SHALL remain in IDLE.
REQ-005 LOAD SHALL last 1 cycle; when row==0 it SHALL snapshot all 64 bits of mat into an internal frame buffer, and it SHALL build a 16-bit word for the current row.
REQ-006 The word SHALL be {rowsel[7:0], coldata[7:0]}:
- rowsel is one-hot with bit row set; it is inverted when ROW_ACTIVE_LOW=1.
- coldata[c] = snapshot[row][c]; it is inverted when COL_ACTIVE_LOW=1.
REQ-007 SHIFT SHALL emit the 16 word bits MSB first (bit 15 first). Each bit SHALL take 2*CLK_DIV cycles:
- ser_clk=0 with ser_data valid for the first CLK_DIV cycles;
- ser_clk=1 for the next CLK_DIV cycles;
- ser_data SHALL NOT change while ser_clk=1.
REQ-008 LATCH SHALL drive ser_latch=1 and ser_clk=0 for exactly CLK_DIV cycles.
REQ-009 HOLD SHALL last exactly HOLD_CYCLES cycles with ser_clk=0 and ser_latch=0.
REQ-010 On leaving HOLD, row SHALL increment modulo 8. On the 7->0 wrap, frame_done SHALL pulse for 1 cycle and the next state SHALL be LOAD if enable=1, otherwise IDLE. For any other row the next state SHALL be LOAD.
REQ-011 Row period SHALL be 1 + 32*CLK_DIV + CLK_DIV + HOLD_CYCLES cycles; with defaults this is 1067 cycles, giving a frame of 8536 cycles.
REQ-012 Deasserting enable mid-frame SHALL NOT abort the scan; the frame SHALL complete through row 7 before entering IDLE.
REQ-013 Changes on mat after the row-0 LOAD SHALL NOT affect the frame in progress; there SHALL be no tearing.
REQ-014 In IDLE, ser_clk, ser_latch and frame_done SHALL be 0, and ser_data SHALL be 0.

Reset
REQ-015 reset SHALL force IDLE with row=0, snapshot=0, shift register=0, all counters=0, and ser_data=ser_clk=ser_latch=frame_done=busy=0 on the next clk edge.
REQ-016 reset SHALL override enable and any state, including mid-SHIFT; after reset is released, the next frame SHALL restart at row 0 with a fresh snapshot.
REQ-017 All outputs SHALL be registered, so no combinational glitch can reach ser_clk or ser_latch.

Structure
REQ-018 A shared package matrix_pkg SHALL hold:
- the scan_state_t enum (IDLE, LOAD, SHIFT, LATCH, HOLD);
- MAT_DIM=8;
- WORD_W=16.
REQ-019 The 16-bit parallel-in/serial-out register SHALL be a sub-module named piso_shift16, with ports load, shift, din[15:0] and dout (current MSB).
REQ-020 The divider, bit, hold and row counters SHALL live in matrix_scan_driver.

Verification
REQ-021 Reset and idle: reset high for 3 cycles, then enable=0 for 100 cycles -> all outputs 0 throughout and busy=0.
REQ-022 Single pixel: mat[2][5]=1, all other cells 0, defaults, enable pulsed 1 cycle:
- row-2 word = 16'hFB20;
- every other row r = {~(1<<r), 8'h00};
- frame_done occurs exactly 8536 cycles after LOAD entry;
- then IDLE.
REQ-023 Bit timing with CLK_DIV=1, HOLD_CYCLES=1, all cells 1, COL_ACTIVE_LOW=1:
- ser_clk toggles every cycle, 16 rising edges per row;
- coldata field = 8'h00;
- ser_latch high for 1 cycle, then 1 HOLD cycle, then LOAD;
- row period = 35 cycles.
REQ-024 Snapshot: mat=64'hFFFF_FFFF_FFFF_FFFF at frame start, changed to 0 during row 3 -> rows 0..7 all shift coldata 8'hFF; the next frame shifts 8'h00.
REQ-025 Mid-frame events:
- enable dropped during row 4 -> rows 4..7 still emitted, frame_done pulses, then IDLE;
- separately, reset asserted mid-SHIFT of row 5 -> outputs 0 next cycle; re-enable restarts at row 0.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and helpers for the LED matrix scan driver.
// The row word is {row select, column data}, shifted MSB first.
package matrix_pkg;

    localparam int MAT_DIM = 8;
    localparam int WORD_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH,
        HOLD
    } scan_state_t;

    function automatic logic [WORD_W-1:0] build_word(
        input logic [2:0]         row,
        input logic [MAT_DIM-1:0] cells,
        input logic               row_low,
        input logic               col_low
    );
        logic [MAT_DIM-1:0] rowsel;
        rowsel = MAT_DIM'(1) << row;
        return {(row_low ? ~rowsel : rowsel), (col_low ? ~cells : cells)};
    endfunction

endpackage

// File: rtl/piso_shift16.sv
// 16-bit parallel-in/serial-out register; dout is always the current MSB.
module piso_shift16
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] din,
    output logic              dout
);

    logic [WORD_W-1:0] shift_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
        end else if (load) begin
            shift_reg <= din;
        end else if (shift) begin
            shift_reg <= {shift_reg[WORD_W-2:0], 1'b0};
        end
    end

    assign dout = shift_reg[WORD_W-1];

endmodule

// File: rtl/matrix_scan_driver.sv
// Scans an 8x8 cell matrix row by row into an external shift-register chain.
// Every output is a flop fed from the current state, so outputs trail the FSM by one cycle.
module matrix_scan_driver
    import matrix_pkg::*;
#(
    parameter int CLK_DIV        = 2,
    parameter int HOLD_CYCLES    = 1000,
    parameter bit ROW_ACTIVE_LOW = 1'b1,
    parameter bit COL_ACTIVE_LOW = 1'b0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [MAT_DIM-1:0][MAT_DIM-1:0] mat,
    output logic                            ser_data,
    output logic                            ser_clk,
    output logic                            ser_latch,
    output logic                            frame_done,
    output logic                            busy
);

    localparam logic [8:0]  DIV_HALF       = 9'(CLK_DIV);
    localparam logic [8:0]  DIV_BIT_LAST   = 9'(2 * CLK_DIV - 1);
    localparam logic [8:0]  DIV_LATCH_LAST = 9'(CLK_DIV - 1);
    localparam logic [15:0] HOLD_LAST      = 16'(HOLD_CYCLES - 1);

    scan_state_t state_reg, state_next;

    logic [8:0]                      div_cnt_reg;
    logic [3:0]                      bit_cnt_reg;
    logic [15:0]                     hold_cnt_reg;
    logic [2:0]                      row_reg;
    logic [MAT_DIM-1:0][MAT_DIM-1:0] snap_reg;

    logic               bit_done, latch_done, hold_done;
    logic [MAT_DIM-1:0] row_cells;
    logic [WORD_W-1:0]  row_word;
    logic               piso_dout;

    logic ser_data_next, ser_clk_next, ser_latch_next, frame_done_next, busy_next;

    assign bit_done   = (div_cnt_reg == DIV_BIT_LAST);
    assign latch_done = (div_cnt_reg == DIV_LATCH_LAST);
    assign hold_done  = (hold_cnt_reg == HOLD_LAST);

    // Row 0 reads mat directly because the snapshot is being captured in that same cycle.
    assign row_cells = (row_reg == 3'd0) ? mat[0] : snap_reg[row_reg];
    assign row_word  = build_word(row_reg, row_cells, ROW_ACTIVE_LOW, COL_ACTIVE_LOW);

    piso_shift16 u_piso (
        .clk   (clk),
        .reset (reset),
        .load  (state_reg == LOAD),
        .shift ((state_reg == SHIFT) && bit_done),
        .din   (row_word),
        .dout  (piso_dout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enable) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (bit_done && (bit_cnt_reg == 4'd15)) state_next = LATCH;
            LATCH:   if (latch_done) state_next = HOLD;
            HOLD:    if (hold_done) state_next = ((row_reg == 3'd7) && !enable) ? IDLE : LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ser_data_next   = 1'b0;
        ser_clk_next    = 1'b0;
        ser_latch_next  = 1'b0;
        frame_done_next = 1'b0;
        busy_next       = (state_reg != IDLE);
        case (state_reg)
            SHIFT: begin
                ser_data_next = piso_dout;
                ser_clk_next  = (div_cnt_reg >= DIV_HALF);
            end
            LATCH:   ser_latch_next  = 1'b1;
            HOLD:    frame_done_next = hold_done && (row_reg == 3'd7);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ser_data   <= 1'b0;
            ser_clk    <= 1'b0;
            ser_latch  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            ser_data   <= ser_data_next;
            ser_clk    <= ser_clk_next;
            ser_latch  <= ser_latch_next;
            frame_done <= frame_done_next;
            busy       <= busy_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
            hold_cnt_reg <= '0;
            row_reg      <= '0;
            snap_reg     <= '0;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (row_reg == 3'd0) snap_reg <= mat;
                end
                SHIFT: begin
                    if (bit_done) begin
                        div_cnt_reg <= '0;
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 9'd1;
                    end
                end
                LATCH: begin
                    div_cnt_reg <= latch_done ? 9'd0 : div_cnt_reg + 9'd1;
                end
                HOLD: begin
                    if (hold_done) begin
                        hold_cnt_reg <= '0;
                        row_reg      <= row_reg + 3'd1;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Scoreboard bench: stimulus pushes expected row words and frame_done times,
// a monitor deserialises the chain, checks timing and pops/compares on each latch.
`timescale 1ns/1ps
module tb_matrix_scan_driver;

    localparam int D0 = 2;
    localparam int H0 = 1000;
    localparam int D1 = 1;
    localparam int H1 = 1;

    typedef struct {
        int          dut;
        int          row;
        logic [15:0] word;
    } exp_word_t;

    typedef struct {
        int     dut;
        longint cyc;
    } exp_fd_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       en;
    logic [7:0][7:0]  mat0, mat1;
    logic [1:0]       sd, sc, sl, fd, bz;

    int     asserts = 0;
    int     fails   = 0;
    longint cyc     = 0;

    exp_word_t wq[$];
    exp_fd_t   fq[$];

    int          latch_cnt [2];
    int          nbits [2];
    logic [15:0] sh [2];
    longint      last_latch [2];
    longint      latch_start [2];
    longint      fd_start [2];
    logic [1:0]  prev_sc, prev_sl, prev_fd, hi_val;
    bit   [1:0]  glitch, have_last;

    matrix_scan_driver dut0 (
        .clk        (clk),
        .reset      (reset),
        .enable     (en[0]),
        .mat        (mat0),
        .ser_data   (sd[0]),
        .ser_clk    (sc[0]),
        .ser_latch  (sl[0]),
        .frame_done (fd[0]),
        .busy       (bz[0])
    );

    matrix_scan_driver #(
        .CLK_DIV        (D1),
        .HOLD_CYCLES    (H1),
        .ROW_ACTIVE_LOW (1'b1),
        .COL_ACTIVE_LOW (1'b1)
    ) dut1 (
        .clk        (clk),
        .reset      (reset),
        .enable     (en[1]),
        .mat        (mat1),
        .ser_data   (sd[1]),
        .ser_clk    (sc[1]),
        .ser_latch  (sl[1]),
        .frame_done (fd[1]),
        .busy       (bz[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int clkdiv_of(input int d);
        return (d == 0) ? D0 : D1;
    endfunction

    function automatic int period_of(input int d);
        return (d == 0) ? (1 + 33 * D0 + H0) : (1 + 33 * D1 + H1);
    endfunction

    // Reference word: active-low one-hot row select, column cells optionally inverted.
    function automatic logic [15:0] model_word(input int d, input int r, input logic [7:0][7:0] m);
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) w[8 + i] = (i == r) ? 1'b0 : 1'b1;
        for (int c = 0; c < 8; c++) w[c] = (d == 1) ? ~m[r][c] : m[r][c];
        return w;
    endfunction

    function automatic int pending(input int d);
        int n;
        n = 0;
        foreach (wq[i]) if (wq[i].dut == d) n++;
        foreach (fq[i]) if (fq[i].dut == d) n++;
        return n;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        asserts++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_frame(input int d, input logic [7:0][7:0] m, input longint load_cyc);
        exp_word_t e;
        exp_fd_t   f;
        for (int r = 0; r < 8; r++) begin
            e.dut  = d;
            e.row  = r;
            e.word = model_word(d, r, m);
            wq.push_back(e);
        end
        f.dut = d;
        f.cyc = load_cyc + 8 * period_of(d);
        fq.push_back(f);
    endtask

    task automatic wait_latches(input int d, input int target, input int budget);
        int k;
        k = 0;
        while (latch_cnt[d] < target && k < budget) begin
            tick(1);
            k++;
        end
        if (latch_cnt[d] < target) check("latch_wait_timeout", latch_cnt[d], target);
    endtask

    task automatic wait_drain(input int d, input int budget);
        int k;
        k = 0;
        while (pending(d) != 0 && k < budget) begin
            tick(1);
            k++;
        end
        if (pending(d) != 0) check("drain_timeout", pending(d), 0);
    endtask

    task automatic flush(input int d);
        for (int i = wq.size() - 1; i >= 0; i--) if (wq[i].dut == d) wq.delete(i);
        for (int i = fq.size() - 1; i >= 0; i--) if (fq[i].dut == d) fq.delete(i);
    endtask

    // Monitor
    initial begin
        int        idx;
        exp_word_t e;
        exp_fd_t   f;
        for (int d = 0; d < 2; d++) begin
            latch_cnt[d] = 0; nbits[d] = 0; sh[d] = '0;
            last_latch[d] = 0; latch_start[d] = 0; fd_start[d] = 0;
        end
        prev_sc = '0; prev_sl = '0; prev_fd = '0; hi_val = '0; glitch = '0; have_last = '0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (reset) begin
                    nbits[d]     = 0;
                    glitch[d]    = 1'b0;
                    have_last[d] = 1'b0;
                end else begin
                    if (sc[d] && !prev_sc[d]) begin
                        sh[d]     = {sh[d][14:0], sd[d]};
                        nbits[d]  = nbits[d] + 1;
                        hi_val[d] = sd[d];
                    end else if (sc[d] && (sd[d] != hi_val[d])) begin
                        glitch[d] = 1'b1;
                    end
                    if (sl[d] && sc[d]) check("latch_during_ser_clk", 1, 0);
                    if (sl[d] && !prev_sl[d]) begin
                        latch_cnt[d]   = latch_cnt[d] + 1;
                        latch_start[d] = cyc;
                        idx = -1;
                        for (int i = 0; i < wq.size(); i++) begin
                            if (wq[i].dut == d) begin
                                idx = i;
                                break;
                            end
                        end
                        check("latch_expected", (idx >= 0) ? 1 : 0, 1);
                        if (idx >= 0) begin
                            e = wq[idx];
                            wq.delete(idx);
                            $display("dut%0d row %0d word=%h expected=%h bits=%0d cycle=%0d",
                                     d, e.row, sh[d], e.word, nbits[d], cyc);
                            check("row_word", longint'(sh[d]), longint'(e.word));
                            check("bits_per_row", nbits[d], 16);
                            check("data_stable_while_clk_high", glitch[d], 0);
                            if (e.row != 0 && have_last[d])
                                check("row_period", cyc - last_latch[d], period_of(d));
                        end
                        last_latch[d] = cyc;
                        have_last[d]  = 1'b1;
                        nbits[d]      = 0;
                        glitch[d]     = 1'b0;
                    end
                    if (!sl[d] && prev_sl[d]) check("latch_width", cyc - latch_start[d], clkdiv_of(d));
                    if (fd[d] && !prev_fd[d]) begin
                        fd_start[d] = cyc;
                        idx = -1;
                        for (int i = 0; i < fq.size(); i++) begin
                            if (fq[i].dut == d) begin
                                idx = i;
                                break;
                            end
                        end
                        check("frame_done_expected", (idx >= 0) ? 1 : 0, 1);
                        if (idx >= 0) begin
                            f = fq[idx];
                            fq.delete(idx);
                            $display("dut%0d frame_done cycle=%0d expected=%0d", d, cyc, f.cyc);
                            check("frame_done_cycle", cyc, f.cyc);
                        end
                    end
                    if (!fd[d] && prev_fd[d]) check("frame_done_width", cyc - fd_start[d], 1);
                end
                prev_sc[d] = sc[d];
                prev_sl[d] = sl[d];
                prev_fd[d] = fd[d];
            end
        end
    end

    // Stimulus
    initial begin
        longint load;
        int     base;
        reset = 1'b1;
        en    = '0;
        mat0  = '0;
        mat1  = '0;
        tick(3);
        check("reset_outputs_dut0", longint'({sd[0], sc[0], sl[0], fd[0], bz[0]}), 0);
        reset = 1'b0;

        // Idle with enable low
        repeat (100) begin
            tick(1);
            check("idle_outputs_dut0", longint'({sd[0], sc[0], sl[0], fd[0], bz[0]}), 0);
            check("idle_outputs_dut1", longint'({sd[1], sc[1], sl[1], fd[1], bz[1]}), 0);
        end

        // Single pixel at row 2, column 5, one-cycle enable pulse
        mat0       = '0;
        mat0[2][5] = 1'b1;
        en[0]      = 1'b1;
        load       = cyc + 1;
        push_frame(0, mat0, load);
        tick(1);
        en[0] = 1'b0;
        tick(1);
        check("busy_after_start", bz[0], 1);
        wait_drain(0, 9000);
        tick(3);
        check("idle_after_pixel_frame", longint'({bz[0], sc[0], sl[0]}), 0);

        // Fast configuration: all ones, then a random frame back to back
        mat1  = '1;
        en[1] = 1'b1;
        load  = cyc + 1;
        base  = latch_cnt[1];
        push_frame(1, mat1, load);
        wait_latches(1, base + 1, 100);
        mat1 = {$urandom, $urandom};
        push_frame(1, mat1, load + 8 * period_of(1));
        wait_latches(1, base + 9, 600);
        en[1] = 1'b0;
        wait_drain(1, 600);
        tick(3);
        check("idle_after_fast_frames", bz[1], 0);

        // Snapshot: mat cleared during row 3 must not disturb this frame; enable dropped in row 4 of the next
        mat0  = '1;
        en[0] = 1'b1;
        load  = cyc + 1;
        base  = latch_cnt[0];
        push_frame(0, mat0, load);
        wait_latches(0, base + 4, 5000);
        mat0 = '0;
        push_frame(0, mat0, load + 8 * period_of(0));
        wait_latches(0, base + 13, 11000);
        en[0] = 1'b0;
        wait_drain(0, 5000);
        tick(3);
        check("idle_after_enable_drop", bz[0], 0);

        // Reset in the middle of row 5 SHIFT, then a fresh random frame from row 0
        mat0  = {$urandom, $urandom};
        en[0] = 1'b1;
        load  = cyc + 1;
        base  = latch_cnt[0];
        push_frame(0, mat0, load);
        wait_latches(0, base + 5, 6000);
        tick(1020);
        reset = 1'b1;
        tick(1);
        check("reset_ser_data", sd[0], 0);
        check("reset_ser_clk", sc[0], 0);
        check("reset_ser_latch", sl[0], 0);
        check("reset_frame_done", fd[0], 0);
        check("reset_busy", bz[0], 0);
        en[0] = 1'b0;
        flush(0);
        tick(1);
        reset = 1'b0;
        tick(2);
        mat0  = {$urandom, $urandom};
        en[0] = 1'b1;
        load  = cyc + 1;
        push_frame(0, mat0, load);
        tick(1);
        en[0] = 1'b0;
        wait_drain(0, 9000);
        tick(3);
        check("idle_after_restart", bz[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
